// File: rtl/wb_master_arbiter_if.sv
// rtl/wb_master_arbiter_if.sv - two-master / one-slave Wishbone bus bundle for wb_master_arbiter
//
// Purpose : groups the two master-side ports and the shared slave-side port of
//           the arbiter. Signal suffixes are from the arbiter's point of view.
// Modports: slave  - the arbiter (takes Mn_*_i and S_DAT_i/S_ACK_i, drives the rest)
//           master - the environment (masters plus the shared slave)
// Params  : ADDRWIDTH (word address width), DATAWIDTH (data width)

interface wb_master_arbiter_if #(
    parameter int ADDRWIDTH = 7,
    parameter int DATAWIDTH = 32
) ();
    logic [ADDRWIDTH-1:0] M0_ADR_i;
    logic [DATAWIDTH-1:0] M0_DAT_i;
    logic                 M0_WE_i;
    logic                 M0_CYC_i;
    logic                 M0_STB_i;
    logic [DATAWIDTH-1:0] M0_DAT_o;
    logic                 M0_ACK_o;

    logic [ADDRWIDTH-1:0] M1_ADR_i;
    logic [DATAWIDTH-1:0] M1_DAT_i;
    logic                 M1_WE_i;
    logic                 M1_CYC_i;
    logic                 M1_STB_i;
    logic [DATAWIDTH-1:0] M1_DAT_o;
    logic                 M1_ACK_o;

    logic [ADDRWIDTH-1:0] S_ADR_o;
    logic [DATAWIDTH-1:0] S_DAT_o;
    logic                 S_WE_o;
    logic                 S_CYC_o;
    logic                 S_STB_o;
    logic [DATAWIDTH-1:0] S_DAT_i;
    logic                 S_ACK_i;

    modport slave (
        input  M0_ADR_i, M0_DAT_i, M0_WE_i, M0_CYC_i, M0_STB_i,
        output M0_DAT_o, M0_ACK_o,
        input  M1_ADR_i, M1_DAT_i, M1_WE_i, M1_CYC_i, M1_STB_i,
        output M1_DAT_o, M1_ACK_o,
        output S_ADR_o, S_DAT_o, S_WE_o, S_CYC_o, S_STB_o,
        input  S_DAT_i, S_ACK_i
    );

    modport master (
        output M0_ADR_i, M0_DAT_i, M0_WE_i, M0_CYC_i, M0_STB_i,
        input  M0_DAT_o, M0_ACK_o,
        output M1_ADR_i, M1_DAT_i, M1_WE_i, M1_CYC_i, M1_STB_i,
        input  M1_DAT_o, M1_ACK_o,
        input  S_ADR_o, S_DAT_o, S_WE_o, S_CYC_o, S_STB_o,
        output S_DAT_i, S_ACK_i
    );
endinterface

// File: rtl/wb_master_arbiter.sv
// rtl/wb_master_arbiter.sv - round-robin two-master Wishbone arbiter with optional ack timeout
//
// Purpose : shares one Wishbone slave bus between two masters. Grants are
//           round-robin on ties, at least one IDLE cycle separates grants, and
//           the owner's signals are passed combinationally to the slave.
// Ports   : WBs_CLK_i  - bus clock
//           WBs_RST_i  - synchronous active-high reset
//           bus        - wb_master_arbiter_if.slave (master 0/1 ports, shared slave port)
//           Grant_o    - one-hot current owner, 2'b00 when idle
//           Timeout_o  - one-cycle pulse when a transfer is terminated by timeout
// Macro   : WB_ARB_TIMEOUT_EN - when defined, a granted transfer that sees no
//           slave ack for TIMEOUT_CYCLES cycles is completed with TIMEOUT_DATA.

module wb_master_arbiter #(
    parameter int                   ADDRWIDTH      = 7,
    parameter int                   DATAWIDTH      = 32,
    parameter int                   TIMEOUT_CYCLES = 7,
    parameter logic [DATAWIDTH-1:0] TIMEOUT_DATA   = 32'hDEF_FAB_AC
) (
    input  logic                    WBs_CLK_i,
    input  logic                    WBs_RST_i,
    wb_master_arbiter_if.slave      bus,
    output logic [1:0]              Grant_o,
    output logic                    Timeout_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_master_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        TOACK = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last;     // master granted most recently; the other one wins a tie
    logic   r_owner;    // master of the current/last grant, selects the TOACK target

    logic w_req0;
    logic w_req1;
    logic w_timeout_hit;

    assign w_req0 = bus.M0_CYC_i & bus.M0_STB_i;
    assign w_req1 = bus.M1_CYC_i & bus.M1_STB_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_cnt;  // number of the current granted cycle, 1 on the first

    assign w_timeout_hit = (r_cnt == TO_LIMIT);

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_cnt <= 8'd0;
        end else if (r_state == IDLE && (w_next == GNT0 || w_next == GNT1)) begin
            r_cnt <= 8'd1;
        end else if ((r_state == GNT0 || r_state == GNT1) && w_next == r_state) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign Timeout_o = (r_state == TOACK);
`else
    assign w_timeout_hit = 1'b0;
    assign Timeout_o     = 1'b0;
`endif

    // State register plus grant bookkeeping captured on entry to a grant.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == GNT0) begin
                r_last  <= 1'b0;
                r_owner <= 1'b0;
            end else if (r_state == IDLE && w_next == GNT1) begin
                r_last  <= 1'b1;
                r_owner <= 1'b1;
            end
        end
    end

    // Next state. Slave ack beats abort, abort beats timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = r_last ? GNT0 : GNT1;
                end else if (w_req0) begin
                    w_next = GNT0;
                end else if (w_req1) begin
                    w_next = GNT1;
                end
            end
            GNT0: begin
                if (bus.S_ACK_i) begin
                    w_next = IDLE;
                end else if (!bus.M0_CYC_i) begin
                    w_next = IDLE;
                end else if (w_timeout_hit) begin
                    w_next = TOACK;
                end
            end
            GNT1: begin
                if (bus.S_ACK_i) begin
                    w_next = IDLE;
                end else if (!bus.M1_CYC_i) begin
                    w_next = IDLE;
                end else if (w_timeout_hit) begin
                    w_next = TOACK;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    logic [ADDRWIDTH-1:0] w_s_adr;
    logic [DATAWIDTH-1:0] w_s_dat;
    logic                 w_s_we;
    logic                 w_s_cyc;
    logic                 w_s_stb;
    logic [DATAWIDTH-1:0] w_m0_dat;
    logic [DATAWIDTH-1:0] w_m1_dat;
    logic                 w_m0_ack;
    logic                 w_m1_ack;
    logic [1:0]           w_grant;

    // Bus steering: everything is zero outside a grant, except the
    // synthesized ack/data returned to the owner in TOACK.
    always_comb begin
        w_s_adr  = '0;
        w_s_dat  = '0;
        w_s_we   = 1'b0;
        w_s_cyc  = 1'b0;
        w_s_stb  = 1'b0;
        w_m0_dat = '0;
        w_m1_dat = '0;
        w_m0_ack = 1'b0;
        w_m1_ack = 1'b0;
        w_grant  = 2'b00;
        case (r_state)
            GNT0: begin
                w_s_adr  = bus.M0_ADR_i;
                w_s_dat  = bus.M0_DAT_i;
                w_s_we   = bus.M0_WE_i;
                w_s_cyc  = bus.M0_CYC_i;
                w_s_stb  = bus.M0_STB_i;
                w_m0_ack = bus.S_ACK_i;
                w_m0_dat = bus.S_DAT_i;
                w_grant  = 2'b01;
            end
            GNT1: begin
                w_s_adr  = bus.M1_ADR_i;
                w_s_dat  = bus.M1_DAT_i;
                w_s_we   = bus.M1_WE_i;
                w_s_cyc  = bus.M1_CYC_i;
                w_s_stb  = bus.M1_STB_i;
                w_m1_ack = bus.S_ACK_i;
                w_m1_dat = bus.S_DAT_i;
                w_grant  = 2'b10;
            end
            TOACK: begin
                if (r_owner) begin
                    w_m1_ack = 1'b1;
                    w_m1_dat = TIMEOUT_DATA;
                    w_grant  = 2'b10;
                end else begin
                    w_m0_ack = 1'b1;
                    w_m0_dat = TIMEOUT_DATA;
                    w_grant  = 2'b01;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.S_ADR_o  = w_s_adr;
    assign bus.S_DAT_o  = w_s_dat;
    assign bus.S_WE_o   = w_s_we;
    assign bus.S_CYC_o  = w_s_cyc;
    assign bus.S_STB_o  = w_s_stb;
    assign bus.M0_DAT_o = w_m0_dat;
    assign bus.M1_DAT_o = w_m1_dat;
    assign bus.M0_ACK_o = w_m0_ack;
    assign bus.M1_ACK_o = w_m1_ack;
    assign Grant_o      = w_grant;

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter ADDRWIDTH, default 7, word-address width of the shared Wishbone bus.
REQ-002 Parameter DATAWIDTH, default 32, data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 7, number of granted cycles to wait for a slave ack (range 1..255).
REQ-004 Parameter TIMEOUT_DATA, default 32'hDEF_FAB_AC, read data returned on a timed-out transfer.
REQ-005 WBs_CLK_i  in  1  bus clock; single clock domain.
REQ-006 WBs_RST_i  in  1  reset, synchronous, active-high.
REQ-007 Mn_ADR_i (n=0,1)  in  ADDRWIDTH  master n address.
REQ-008 Mn_DAT_i  in  DATAWIDTH  master n write data.
REQ-009 Mn_WE_i  in  1  master n write enable.
REQ-010 Mn_CYC_i / Mn_STB_i  in  1 each  master n cycle and strobe.
REQ-011 Mn_DAT_o  out  DATAWIDTH  master n read data.
REQ-012 Mn_ACK_o  out  1  master n acknowledge.
REQ-013 S_ADR_o, S_DAT_o, S_WE_o, S_CYC_o, S_STB_o  out  ADDRWIDTH, DATAWIDTH, 1, 1, 1  shared slave bus.
REQ-014 S_DAT_i  in  DATAWIDTH and S_ACK_i  in  1  shared slave read data and OR-ed slave ack.
REQ-015 Grant_o  out  2  one-hot current owner (bit n = master n); 2'b00 when idle.
REQ-016 Timeout_o  out  1  one-cycle pulse on a timed-out transfer.

Function
REQ-017 States SHALL be IDLE, GNT0, GNT1 and TOACK.
REQ-018 Master n requests when Mn_CYC_i and Mn_STB_i are both 1.
REQ-019 In IDLE with one request, the next state SHALL be GNTn; with both, grant SHALL go to the master not granted last (round-robin).
REQ-020 In GNTn, S_* outputs SHALL combinationally mirror master n; in IDLE and TOACK, S_CYC_o, S_STB_o and S_WE_o SHALL be 0 and S_ADR_o and S_DAT_o SHALL be 0.
REQ-021 In GNTn, Mn_ACK_o SHALL equal S_ACK_i and Mn_DAT_o SHALL equal S_DAT_i; the non-granted master's ACK and DAT SHALL be 0.
REQ-022 In GNTn, S_ACK_i=1 SHALL end the transfer: the next state is IDLE, and last-granted is updated to n.
REQ-023 In GNTn, Mn_CYC_i=0 without S_ACK_i (abort) SHALL return to IDLE with no ack.
REQ-024 Timeout counter: loaded with 1 on entry to GNTn and incremented on each GNTn cycle without ack; counter==TIMEOUT_CYCLES with S_ACK_i=0 SHALL move to TOACK.
REQ-025 If S_ACK_i and the timeout condition occur in the same cycle, the slave ack SHALL win and TOACK SHALL not be entered.
REQ-026 TOACK SHALL last exactly one cycle, with Mn_ACK_o=1 for the owning master, Mn_DAT_o=TIMEOUT_DATA and Timeout_o=1, then go to IDLE.
REQ-027 At least one IDLE cycle SHALL separate consecutive grants; S_ACK_i in IDLE or TOACK SHALL be ignored.
REQ-028 Grant_o SHALL be 2'b01 in GNT0 and TOACK-after-GNT0, 2'b10 for master 1, and 2'b00 in IDLE.

Reset
REQ-029 WBs_RST_i=1 at a clock edge SHALL force IDLE, counter 0 and last-granted=M1 (M0 wins the first tie).
REQ-030 After reset, all outputs SHALL be 0, including mid-transfer reset; an in-flight transfer SHALL be dropped with no ack.

Configuration
REQ-031 Macro WB_ARB_TIMEOUT_EN defined: timeout logic per REQ-024..026 SHALL be present.
REQ-032 Macro WB_ARB_TIMEOUT_EN undefined: no counter SHALL exist, TOACK SHALL be unreachable, Timeout_o SHALL be tied 0, and GNTn SHALL hold until S_ACK_i or an abort.

Verification
REQ-033 M0 read at address 0x10, slave acks in 3rd granted cycle with 0x1234 -> Grant_o=01, M0_ACK_o=1 with M0_DAT_o=0x1234, M1_ACK_o=0.
REQ-034 M0 and M1 request in the same cycle after reset, both held -> M0 granted first, then IDLE, then M1; a third tie goes to M0.
REQ-035 M1 write with no slave ack (timeout enabled) -> 7 GNT1 cycles, then TOACK with M1_ACK_o=1, M1_DAT_o=0xDEFFABAC and Timeout_o=1 for one cycle.
REQ-036 S_ACK_i asserted in the 7th granted cycle -> normal ack, Timeout_o stays 0.
REQ-037 M0 drops CYC in the 2nd granted cycle -> IDLE next, no M0_ACK_o; a late S_ACK_i is ignored.
REQ-038 WBs_RST_i pulsed during GNT1 -> next cycle IDLE, all outputs 0, and a subsequent tie is granted to M0.
